vai_tx_sched: RTL and testbench
===============================

Name: vai_tx_sched

Overview:
- Per-channel scheduler that shares the upstream CCI-P Tx request port among NUM_SUB_AFUS audited sub-AFU request streams.
- Sits between the per-AFU Tx audit stage and the upstream Tx register stage. Replaces the legacy mux's fixed arbitration with weighted round-robin.
- Keeps multi-line c1 write bursts atomic and honours upstream almost-full with a bounded in-flight allowance.

Parameters:
- NUM_SUB_AFUS, 8, number of requesters; 2..16.
- WEIGHT_W, 4, width of per-AFU weight (grants per round-robin turn).
- ALMFULL_SLACK, 4, max grants issued per channel after almost-full asserts (CCI-P tolerates 8).

Ports:
- pClk, in, 1, clock.
- SoftReset_n, in, 1, asynchronous active-low reset.
- up_c0TxAlmFull, in, 1, upstream c0 almost-full.
- up_c1TxAlmFull, in, 1, upstream c1 almost-full.
- afu_c0_req, in, NUM_SUB_AFUS, per-AFU c0 read request pending.
- afu_c1_req, in, NUM_SUB_AFUS, per-AFU c1 write beat pending.
- afu_c1_sop, in, NUM_SUB_AFUS, pending c1 beat is first of its burst.
- afu_c1_len, in, 2*NUM_SUB_AFUS, cl_len of each pending sop beat (0=1 line .. 3=4 lines).
- afu_weight, in, WEIGHT_W*NUM_SUB_AFUS, per-AFU weight; sampled at turn start; 0 treated as 1.
- c0_grant, out, NUM_SUB_AFUS, one-hot c0 grant, registered.
- c1_grant, out, NUM_SUB_AFUS, one-hot c1 grant, registered.
- c0_grant_valid, out, 1, OR of c0_grant.
- c1_grant_valid, out, 1, OR of c1_grant.

Behaviour:
- Reset: all grants and grant_valids 0, round-robin pointers 0, weight counters 0, slack counters 0, c1 FSM IDLE. Reset is asynchronous assert, synchronous deassert (external synchroniser).
- Latency: request sampled in cycle N produces grant in cycle N+1. The AFU pops its entry in N+1 when its grant bit is 1. A request held across a grant counts again, so AFUs must deassert or advance in N+1.
- Channel arbitration (c0 and c1 independent):
  - Search starts at the current pointer and takes the first requesting AFU.
  - Owner keeps the turn until it has received max(weight,1) grants, or stops requesting. The pointer then moves to owner+1 mod NUM_SUB_AFUS.
  - Weight counter reloads on every turn change.
- Almost-full:
  - While AlmFull is 0, the slack counter clears.
  - While AlmFull is 1, each grant increments the counter. Once it reaches ALMFULL_SLACK, no new grants issue.
  - Grants resume the cycle after AlmFull falls.
- c1 FSM, two states:
  - IDLE: grant only an AFU with sop=1. Load remaining = len. If len>0, go to BURST.
  - BURST: grant only the locked AFU. Decrement remaining per grant. Return to IDLE on the grant with remaining==0.
  - Weight expiry mid-burst is deferred to burst end.
  - Almost-full throttling still applies in BURST; the burst pauses but stays locked.
  - Locked AFU not requesting means no grant (bubble). Other AFUs stay blocked.
- Simultaneous events:
  - Weight expiry coinciding with the owner dropping its request advances the pointer once, not twice.
  - AlmFull rising in the same cycle as a grant counts that grant.
- Boundaries:
  - Pointer wraps NUM_SUB_AFUS-1 -> 0.
  - Single requester receives back-to-back grants every cycle, subject to AlmFull.
  - No requests: pointer holds.
- Mid-operation reset clears the burst lock. Partial bursts are discarded by the upstream reset.

Optional Feature:
- VAI_TX_SCHED_STATS_EN: adds output grant_cnt, 32*NUM_SUB_AFUS bits. Each counter holds c0+c1 grants per AFU, wraps at 2^32, and clears on reset.
- Also adds output stall_cnt, 32 bits, counting cycles where any request was pending but blocked by almost-full.
- Without the macro, neither port exists and no counter logic is synthesised.

Decomposition:
- Package vai_sched_pkg:
  - t_sub_afu_idx (clog2 index).
  - t_c1_state enum {C1_IDLE, C1_BURST}.
  - constant CCIP_TX_ALMFULL_MAX = 8. Elaborate-time check that ALMFULL_SLACK < CCIP_TX_ALMFULL_MAX.
- One sub-module vai_wrr_pick, instantiated once per channel. It contains the pointer, weight counter and one-hot rotate-priority pick, with a hold input used by the c1 burst lock.

Test Plan:
- Equal weights 1, AFUs 0,3,5 requesting c0 continuously -> c0_grant cycles 0,3,5,0,... one per cycle from cycle 1 after request.
- Weights AFU0=3, AFU1=1, both requesting c0 -> grant pattern 0,0,0,1 repeating.
- AFU2 c1 sop len=3 with AFU4 also requesting -> four consecutive grants to AFU2, then AFU4. AFU4 never granted inside the burst.
- up_c1TxAlmFull held 1 with ALMFULL_SLACK=4, AFU1 requesting -> exactly 4 grants, then none. Grants resume the cycle after AlmFull drops.
- Reset asserted mid c1 burst (after 2 of 4 beats) -> grants 0 immediately (async). After release, FSM is IDLE and the next grant requires sop=1.
- No requests for 10 cycles after traffic -> grant_valid 0 throughout; pointer unchanged (next grant goes to the expected AFU).

Source files
------------

// File: rtl/vai_sched_pkg.sv
// rtl/vai_sched_pkg.sv - shared types and limits for the VAI Tx scheduler
package vai_sched_pkg;

  localparam int SUB_AFU_MAX         = 16;
  localparam int SUB_AFU_IDX_W       = $clog2(SUB_AFU_MAX);
  localparam int CCIP_TX_ALMFULL_MAX = 8;
  localparam int SLACK_W             = 4;

  typedef logic [SUB_AFU_IDX_W-1:0] t_sub_afu_idx;

  typedef enum logic {
    C1_IDLE  = 1'b0,
    C1_BURST = 1'b1
  } t_c1_state;

  function automatic t_sub_afu_idx idx_inc(t_sub_afu_idx i, int n);
    return (int'(i) == n - 1) ? '0 : i + t_sub_afu_idx'(1);
  endfunction

endpackage

// File: rtl/vai_wrr_pick.sv
// rtl/vai_wrr_pick.sv - weighted round-robin pick for one Tx channel
// The pointer sits on the turn owner while its turn is open, so the rotate search naturally favours it.
module vai_wrr_pick
  import vai_sched_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 8,
  parameter int WEIGHT_W     = 4
) (
  input  logic                             pClk,
  input  logic                             SoftReset_n,
  input  logic [NUM_SUB_AFUS-1:0]          i_req,
  input  logic                             i_en,
  input  logic                             i_hold,
  input  logic [WEIGHT_W*NUM_SUB_AFUS-1:0] i_weight,
  output logic [NUM_SUB_AFUS-1:0]          o_gnt,
  output logic                             o_gnt_any
);

  t_sub_afu_idx        r_ptr;
  logic                r_active;
  logic [WEIGHT_W-1:0] r_rem;

  t_sub_afu_idx        w_win;
  logic                w_found;
  logic                w_own_req;
  logic                w_cont;
  logic [WEIGHT_W-1:0] w_wt;
  logic [WEIGHT_W-1:0] w_rem_nxt;

  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_SUB_AFUS; k++) begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        if (!w_found && i_req[i] && (i == (int'(r_ptr) + k) % NUM_SUB_AFUS)) begin
          w_found = 1'b1;
          w_win   = t_sub_afu_idx'(i);
        end
      end
    end
  end

  always_comb begin
    o_gnt     = '0;
    w_wt      = '0;
    w_own_req = 1'b0;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      o_gnt[i] = w_found && i_en && (int'(w_win) == i);
      if (int'(w_win) == i) w_wt = i_weight[i*WEIGHT_W +: WEIGHT_W];
      if (int'(r_ptr) == i) w_own_req = i_req[i];
    end
  end

  assign o_gnt_any = w_found && i_en;
  assign w_cont    = r_active && (w_win == r_ptr);

  // Remaining count saturates at zero so an expiry held off by i_hold fires on the next unheld grant.
  always_comb begin
    if (w_cont) w_rem_nxt = (r_rem == '0) ? '0 : r_rem - WEIGHT_W'(1);
    else        w_rem_nxt = (w_wt == '0) ? '0 : w_wt - WEIGHT_W'(1);
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_ptr    <= '0;
      r_active <= 1'b0;
      r_rem    <= '0;
    end else if (o_gnt_any) begin
      if (!i_hold && (w_rem_nxt == '0)) begin
        r_ptr    <= idx_inc(w_win, NUM_SUB_AFUS);
        r_active <= 1'b0;
        r_rem    <= '0;
      end else begin
        r_ptr    <= w_win;
        r_active <= 1'b1;
        r_rem    <= w_rem_nxt;
      end
    end else if (r_active && !i_hold && !w_own_req) begin
      r_ptr    <= idx_inc(r_ptr, NUM_SUB_AFUS);
      r_active <= 1'b0;
      r_rem    <= '0;
    end
  end

endmodule

// File: rtl/vai_tx_sched.sv
// rtl/vai_tx_sched.sv - WRR scheduler sharing the CCI-P Tx port among sub-AFUs
// Optional VAI_TX_SCHED_STATS_EN adds per-AFU grant counters and an almost-full stall counter.
module vai_tx_sched
  import vai_sched_pkg::*;
#(
  parameter int NUM_SUB_AFUS  = 8,
  parameter int WEIGHT_W      = 4,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic                             pClk,
  input  logic                             SoftReset_n,
  input  logic                             up_c0TxAlmFull,
  input  logic                             up_c1TxAlmFull,
  input  logic [NUM_SUB_AFUS-1:0]          afu_c0_req,
  input  logic [NUM_SUB_AFUS-1:0]          afu_c1_req,
  input  logic [NUM_SUB_AFUS-1:0]          afu_c1_sop,
  input  logic [2*NUM_SUB_AFUS-1:0]        afu_c1_len,
  input  logic [WEIGHT_W*NUM_SUB_AFUS-1:0] afu_weight,
  output logic [NUM_SUB_AFUS-1:0]          c0_grant,
  output logic [NUM_SUB_AFUS-1:0]          c1_grant,
  output logic                             c0_grant_valid,
  output logic                             c1_grant_valid
`ifdef VAI_TX_SCHED_STATS_EN
  ,
  output logic [32*NUM_SUB_AFUS-1:0]       grant_cnt,
  output logic [31:0]                      stall_cnt
`endif
);

  if ((ALMFULL_SLACK >= CCIP_TX_ALMFULL_MAX) || (NUM_SUB_AFUS < 2) || (NUM_SUB_AFUS > SUB_AFU_MAX)) begin : g_param_check
    $error("vai_tx_sched: ALMFULL_SLACK or NUM_SUB_AFUS out of range");
  end

  logic [SLACK_W-1:0]      r_c0_slack;
  logic [SLACK_W-1:0]      r_c1_slack;
  logic [NUM_SUB_AFUS-1:0] r_c0_gnt;
  logic [NUM_SUB_AFUS-1:0] r_c1_gnt;
  t_c1_state               r_c1_state;
  logic [NUM_SUB_AFUS-1:0] r_c1_lock;
  logic [1:0]              r_c1_rem;

  logic                    w_c0_en;
  logic                    w_c1_en;
  logic [NUM_SUB_AFUS-1:0] w_c0_gnt;
  logic [NUM_SUB_AFUS-1:0] w_c1_gnt;
  logic                    w_c0_gnt_any;
  logic                    w_c1_gnt_any;
  logic [NUM_SUB_AFUS-1:0] w_c1_elig;
  logic [1:0]              w_c1_len;
  logic                    w_c1_hold;

  assign w_c0_en = !(up_c0TxAlmFull && (int'(r_c0_slack) >= ALMFULL_SLACK));
  assign w_c1_en = !(up_c1TxAlmFull && (int'(r_c1_slack) >= ALMFULL_SLACK));

  // Outside a burst only burst heads compete; inside one only the locked AFU is visible.
  assign w_c1_elig = (r_c1_state == C1_BURST) ? (afu_c1_req & r_c1_lock)
                                              : (afu_c1_req & afu_c1_sop);

  always_comb begin
    w_c1_len = '0;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      if (w_c1_gnt[i]) w_c1_len = afu_c1_len[2*i +: 2];
    end
  end

  assign w_c1_hold = (r_c1_state == C1_BURST) ? !(w_c1_gnt_any && (r_c1_rem == 2'd0))
                                              : (w_c1_gnt_any && (w_c1_len != 2'd0));

  vai_wrr_pick #(.NUM_SUB_AFUS(NUM_SUB_AFUS), .WEIGHT_W(WEIGHT_W)) u_c0_pick (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .i_req       (afu_c0_req),
    .i_en        (w_c0_en),
    .i_hold      (1'b0),
    .i_weight    (afu_weight),
    .o_gnt       (w_c0_gnt),
    .o_gnt_any   (w_c0_gnt_any)
  );

  vai_wrr_pick #(.NUM_SUB_AFUS(NUM_SUB_AFUS), .WEIGHT_W(WEIGHT_W)) u_c1_pick (
    .pClk        (pClk),
    .SoftReset_n (SoftReset_n),
    .i_req       (w_c1_elig),
    .i_en        (w_c1_en),
    .i_hold      (w_c1_hold),
    .i_weight    (afu_weight),
    .o_gnt       (w_c1_gnt),
    .o_gnt_any   (w_c1_gnt_any)
  );

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_c0_slack <= '0;
      r_c1_slack <= '0;
      r_c0_gnt   <= '0;
      r_c1_gnt   <= '0;
    end else begin
      r_c0_gnt <= w_c0_gnt;
      r_c1_gnt <= w_c1_gnt;
      if (!up_c0TxAlmFull)  r_c0_slack <= '0;
      else if (w_c0_gnt_any) r_c0_slack <= r_c0_slack + SLACK_W'(1);
      if (!up_c1TxAlmFull)  r_c1_slack <= '0;
      else if (w_c1_gnt_any) r_c1_slack <= r_c1_slack + SLACK_W'(1);
    end
  end

  // r_c1_rem counts beats still owed after the current one.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_c1_state <= C1_IDLE;
      r_c1_lock  <= '0;
      r_c1_rem   <= '0;
    end else begin
      case (r_c1_state)
        C1_IDLE: begin
          if (w_c1_gnt_any && (w_c1_len != 2'd0)) begin
            r_c1_state <= C1_BURST;
            r_c1_lock  <= w_c1_gnt;
            r_c1_rem   <= w_c1_len - 2'd1;
          end
        end
        C1_BURST: begin
          if (w_c1_gnt_any) begin
            if (r_c1_rem == 2'd0) r_c1_state <= C1_IDLE;
            else                  r_c1_rem   <= r_c1_rem - 2'd1;
          end
        end
        default: r_c1_state <= C1_IDLE;
      endcase
    end
  end

  assign c0_grant       = r_c0_gnt;
  assign c1_grant       = r_c1_gnt;
  assign c0_grant_valid = |r_c0_gnt;
  assign c1_grant_valid = |r_c1_gnt;

`ifdef VAI_TX_SCHED_STATS_EN
  logic [32*NUM_SUB_AFUS-1:0] r_grant_cnt;
  logic [31:0]                r_stall_cnt;

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SUB_AFUS; i++) begin
        r_grant_cnt[32*i +: 32] <= r_grant_cnt[32*i +: 32] + 32'(w_c0_gnt[i]) + 32'(w_c1_gnt[i]);
      end
      if (((|afu_c0_req) && !w_c0_en) || ((|w_c1_elig) && !w_c1_en)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vai_tx_sched.sv
// tb/tb_vai_tx_sched.sv - directed self-checking bench for vai_tx_sched
module tb_vai_tx_sched;

  localparam int N     = 8;
  localparam int W     = 4;
  localparam int SLACK = 4;

  logic           pClk = 1'b0;
  logic           SoftReset_n;
  logic           up_c0TxAlmFull;
  logic           up_c1TxAlmFull;
  logic [N-1:0]   afu_c0_req;
  logic [N-1:0]   afu_c1_req;
  logic [N-1:0]   afu_c1_sop;
  logic [2*N-1:0] afu_c1_len;
  logic [W*N-1:0] afu_weight;
  logic [N-1:0]   c0_grant;
  logic [N-1:0]   c1_grant;
  logic           c0_grant_valid;
  logic           c1_grant_valid;
`ifdef VAI_TX_SCHED_STATS_EN
  logic [32*N-1:0] grant_cnt;
  logic [31:0]     stall_cnt;
`endif

  always #5 pClk = ~pClk;

  vai_tx_sched #(.NUM_SUB_AFUS(N), .WEIGHT_W(W), .ALMFULL_SLACK(SLACK)) dut (
    .pClk           (pClk),
    .SoftReset_n    (SoftReset_n),
    .up_c0TxAlmFull (up_c0TxAlmFull),
    .up_c1TxAlmFull (up_c1TxAlmFull),
    .afu_c0_req     (afu_c0_req),
    .afu_c1_req     (afu_c1_req),
    .afu_c1_sop     (afu_c1_sop),
    .afu_c1_len     (afu_c1_len),
    .afu_weight     (afu_weight),
    .c0_grant       (c0_grant),
    .c1_grant       (c1_grant),
    .c0_grant_valid (c0_grant_valid),
    .c1_grant_valid (c1_grant_valid)
`ifdef VAI_TX_SCHED_STATS_EN
    ,
    .grant_cnt      (grant_cnt),
    .stall_cnt      (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural view: per channel a resume position, the current turn owner (-1 none) and its grant tally.
  int m_ptr   [2];
  int m_owner [2];
  int m_used  [2];
  int m_wt    [2];
  int m_slack [2];
  int m_burst_left;
  int m_lock;

  int t1_exp [6] = '{0, 3, 5, 0, 3, 5};
  int t2_exp [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot(int e);
    return (e < 0) ? 0 : (1 << e);
  endfunction

  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int wt_of(int a);
    int w;
    w = int'(afu_weight[a*W +: W]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_ptr[c] = 0; m_owner[c] = -1; m_used[c] = 0; m_wt[c] = 1; m_slack[c] = 0;
    end
    m_burst_left = 0;
    m_lock       = 0;
  endfunction

  function automatic logic [N-1:0] c1_elig();
    logic [N-1:0] lk;
    lk = '0;
    lk[m_lock] = 1'b1;
    return (m_burst_left > 0) ? (afu_c1_req & lk) : (afu_c1_req & afu_c1_sop);
  endfunction

  function automatic int chan_step(int c, logic [N-1:0] elig, logic alm);
    int  start, win;
    bit  locked, locked_after;
    locked = (c == 1) && (m_burst_left > 0);
    if (m_owner[c] >= 0 && !elig[m_owner[c]] && !locked) begin
      m_ptr[c]   = (m_owner[c] + 1) % N;
      m_owner[c] = -1;
    end
    start = (m_owner[c] >= 0) ? m_owner[c] : m_ptr[c];
    win   = -1;
    for (int k = 0; k < N; k++) if (win < 0 && elig[(start + k) % N]) win = (start + k) % N;
    if (alm && m_slack[c] >= SLACK) win = -1;
    if (!alm) m_slack[c] = 0;
    else if (win >= 0) m_slack[c]++;
    if (win < 0) return -1;
    if (win != m_owner[c]) begin
      m_owner[c] = win; m_used[c] = 0; m_wt[c] = wt_of(win);
    end
    m_used[c]++;
    locked_after = 0;
    if (c == 1) begin
      if (m_burst_left > 0) m_burst_left--;
      else begin
        m_burst_left = int'(afu_c1_len[2*win +: 2]);
        m_lock       = win;
      end
      locked_after = (m_burst_left > 0);
    end
    if (m_used[c] >= m_wt[c] && !locked_after) begin
      m_ptr[c]   = (win + 1) % N;
      m_owner[c] = -1;
    end
    return win;
  endfunction

  // Inputs set now are sampled at the next rising edge; outputs are compared on the falling edge after it.
  task automatic tick();
    int           e0, e1;
    logic [N-1:0] el1;
    if (!SoftReset_n) begin
      model_reset();
      e0 = -1;
      e1 = -1;
    end else begin
      el1 = c1_elig();
      e0  = chan_step(0, afu_c0_req, up_c0TxAlmFull);
      e1  = chan_step(1, el1, up_c1TxAlmFull);
    end
    @(negedge pClk);
    chk("c0_grant", int'(c0_grant), onehot(e0));
    chk("c1_grant", int'(c1_grant), onehot(e1));
    chk("c0_grant_valid", int'(c0_grant_valid), int'(e0 >= 0));
    chk("c1_grant_valid", int'(c1_grant_valid), int'(e1 >= 0));
  endtask

  task automatic set_w(int a, int v);
    afu_weight[a*W +: W] = W'(v);
  endtask

  task automatic set_len(int a, int v);
    afu_c1_len[2*a +: 2] = 2'(v);
  endtask

  initial begin
    int cnt;
    SoftReset_n    = 1'b0;
    up_c0TxAlmFull = 1'b0;
    up_c1TxAlmFull = 1'b0;
    afu_c0_req     = '0;
    afu_c1_req     = '0;
    afu_c1_sop     = '0;
    afu_c1_len     = '0;
    afu_weight     = '0;
    for (int i = 0; i < N; i++) set_w(i, 1);
    repeat (3) @(negedge pClk);
    chk("reset_c0_grant", int'(c0_grant), 0);
    chk("reset_c1_grant", int'(c1_grant), 0);
    chk("reset_valids", int'({c0_grant_valid, c1_grant_valid}), 0);
    model_reset();
    SoftReset_n = 1'b1;
    tick();

    // Equal weights, AFUs 0,3,5 on c0
    afu_c0_req = 8'b0010_1001;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t1_c0_rr_order", idx_of(c0_grant), t1_exp[k]);
    end
    afu_c0_req = '0;
    tick();

    // Weights AFU0=3, AFU1=1
    set_w(0, 3);
    afu_c0_req = 8'b0000_0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_c0_weighted", idx_of(c0_grant), t2_exp[k]);
    end
    afu_c0_req = '0;
    set_w(0, 1);
    tick();

    // AFU2 4-beat burst with AFU4 waiting
    set_len(2, 3);
    set_len(4, 0);
    afu_c1_req = 8'b0001_0100;
    afu_c1_sop = 8'b0001_0100;
    tick();
    chk("t3_burst_head", idx_of(c1_grant), 2);
    afu_c1_sop[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_burst_beat", idx_of(c1_grant), 2);
    end
    afu_c1_req[2] = 1'b0;
    tick();
    chk("t3_after_burst", idx_of(c1_grant), 4);
    afu_c1_req = '0;
    afu_c1_sop = '0;
    tick();
    chk("t3_idle", int'(c1_grant_valid), 0);

    // c1 almost-full slack
    up_c1TxAlmFull = 1'b1;
    afu_c1_req[1]  = 1'b1;
    afu_c1_sop[1]  = 1'b1;
    set_len(1, 0);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (c1_grant == 8'b0000_0010) cnt++;
    end
    chk("t4_grants_under_almfull", cnt, SLACK);
    up_c1TxAlmFull = 1'b0;
    tick();
    chk("t4_resume", idx_of(c1_grant), 1);
    afu_c1_req = '0;
    afu_c1_sop = '0;
    tick();

    // Reset in the middle of a 4-beat burst
    set_len(6, 3);
    afu_c1_req[6] = 1'b1;
    afu_c1_sop[6] = 1'b1;
    tick();
    chk("t5_burst_head", idx_of(c1_grant), 6);
    afu_c1_sop[6] = 1'b0;
    tick();
    chk("t5_burst_beat2", idx_of(c1_grant), 6);
    @(posedge pClk);
    #2;
    SoftReset_n = 1'b0;
    #1;
    chk("t5_async_c1_clear", int'(c1_grant), 0);
    chk("t5_async_valid_clear", int'(c1_grant_valid), 0);
    model_reset();
    @(negedge pClk);
    @(negedge pClk);
    SoftReset_n = 1'b1;
    tick();
    chk("t5_no_grant_without_sop", idx_of(c1_grant), -1);
    afu_c1_sop[6] = 1'b1;
    set_len(6, 0);
    tick();
    chk("t5_sop_after_reset", idx_of(c1_grant), 6);
    afu_c1_req = '0;
    afu_c1_sop = '0;

    // Traffic, ten idle cycles, then pointer position
    afu_c0_req[4] = 1'b1;
    tick();
    chk("t6_traffic", idx_of(c0_grant), 4);
    afu_c0_req = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_idle_valid", int'({c0_grant_valid, c1_grant_valid}), 0);
    end
    set_w(7, 0);
    afu_c0_req = 8'b1000_1000;
    tick();
    chk("t6_ptr_held_first", idx_of(c0_grant), 7);
    tick();
    chk("t6_ptr_held_second", idx_of(c0_grant), 3);
    afu_c0_req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
